// File: rtl/cpu6_pipectl_if.sv
// rtl/cpu6_pipectl_if.sv - pipeline hazard inputs and per-stage hold/bubble strobes for cpu6_pipectl
interface cpu6_pipectl_if;
  logic       branchD;
  logic       memreadE;
  logic [4:0] rdE;
  logic [4:0] rs1D;
  logic [4:0] rs2D;
  logic       dreqM;
  logic       dackM;
  logic       irq;
  logic       stallF;
  logic       stallD;
  logic       stallE;
  logic       stallM;
  logic       flushD;
  logic       flushE;
  logic       irq_take;
  logic       buserr;

  modport master (
    output branchD, memreadE, rdE, rs1D, rs2D, dreqM, dackM, irq,
    input  stallF, stallD, stallE, stallM, flushD, flushE, irq_take, buserr
  );

  modport slave (
    input  branchD, memreadE, rdE, rs1D, rs2D, dreqM, dackM, irq,
    output stallF, stallD, stallE, stallM, flushD, flushE, irq_take, buserr
  );
endinterface

// File: rtl/cpu6_pipectl.sv
// rtl/cpu6_pipectl.sv - cpu6 pipeline stall/flush sequencer; optional data-bus timeout via CPU6_PIPECTL_TIMEOUT_EN
module cpu6_pipectl #(
  parameter int TIMEOUT = 255
) (
  input logic           clk,
  input logic           resetn,
  cpu6_pipectl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BRWAIT = 2'd1,
    IRQ    = 2'd2
  } pipeState;

  pipeState state;
  pipeState stateNxt;

  logic memwait;
  logic loaduse;
  logic buserrInt;

  logic stF;
  logic stD;
  logic stE;
  logic stM;
  logic flD;
  logic flE;
  logic irqTake;

`ifdef CPU6_PIPECTL_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wcnt;

  // Count consecutive wait cycles; an ack, an idle bus or an abort restarts the count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wcnt <= '0;
    end else if (!bus.dreqM || bus.dackM || buserrInt) begin
      wcnt <= '0;
    end else begin
      wcnt <= wcnt + CW'(1);
    end
  end

  assign buserrInt = resetn & bus.dreqM & ~bus.dackM & (wcnt == CW'(TIMEOUT));
`else
  logic [9:0] unusedTimeout;

  assign unusedTimeout = 10'(TIMEOUT);
  assign buserrInt     = 1'b0;
`endif

  // The aborting cycle is not a wait: it lets the pipeline move on.
  assign memwait = bus.dreqM & ~bus.dackM & ~buserrInt;

  // x0 is never a real producer, so a load into it cannot create a hazard.
  assign loaduse = bus.memreadE & (bus.rdE != 5'd0) &
                   ((bus.rdE == bus.rs1D) | (bus.rdE == bus.rs2D));

  // State register; a bus wait freezes whatever state the pipeline is in.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= RUN;
    end else begin
      state <= stateNxt;
    end
  end

  // Fixed-priority arbitration: bus wait, pending bubble states, load-use, branch, irq.
  always_comb begin
    stateNxt = state;
    stF      = 1'b0;
    stD      = 1'b0;
    stE      = 1'b0;
    stM      = 1'b0;
    flD      = 1'b0;
    flE      = 1'b0;
    irqTake  = 1'b0;
    if (resetn) begin
      if (memwait) begin
        stF = 1'b1;
        stD = 1'b1;
        stE = 1'b1;
        stM = 1'b1;
      end else begin
        case (state)
          BRWAIT: begin
            flD      = 1'b1;
            stateNxt = RUN;
          end
          IRQ: begin
            flD      = 1'b1;
            flE      = 1'b1;
            stateNxt = RUN;
          end
          default: begin
            if (loaduse) begin
              // The branch, if any, stays in D and resolves next cycle.
              stF = 1'b1;
              stD = 1'b1;
              flE = 1'b1;
            end else if (bus.branchD) begin
              stF      = 1'b1;
              stateNxt = BRWAIT;
            end else if (bus.irq) begin
              irqTake  = 1'b1;
              stateNxt = IRQ;
            end
          end
        endcase
      end
    end
  end

  assign bus.stallF   = stF;
  assign bus.stallD   = stD;
  assign bus.stallE   = stE;
  assign bus.stallM   = stM;
  assign bus.flushD   = flD;
  assign bus.flushE   = flE;
  assign bus.irq_take = irqTake;
  assign bus.buserr   = buserrInt;

endmodule
